alu_exec_ctrl: RTL
==================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-high.
REQ-003: instr_valid  input  1  instruction offered.
REQ-004: instr_ready  output  1  controller can accept an instruction.
REQ-005: instr  input  8  [7:6] op (00 ADD, 01 SUB, 10 CMP, 11 LDI), [5:4] rd, [3:2] rs1, [1:0] rs2.
REQ-006: imm  input  8  immediate for LDI, sampled with instr.
REQ-007: alu_a  output  8  ALU operand A, registered.
REQ-008: alu_b  output  8  ALU operand B, registered.
REQ-009: alu_fs  output  2  ALU function select, registered; equals latched op.
REQ-010: alu_c  input  8  ALU result.
REQ-011: alu_flag  input  4  ALU flags: [3] compare-equal, [2] zero, [1] unused, [0] carry/borrow.
REQ-012: flags_q  output  4  architectural flag register, same bit layout.
REQ-013: done  output  1  one-cycle pulse in the writeback cycle.
REQ-014: rd_sel  input  2  debug read select.
REQ-015: rd_data  output  8  combinational read of R[rd_sel].

Function
REQ-016: Register file: four 8-bit registers R0-R3, written only in writeback.
REQ-017: FSM states: IDLE, READ, EXEC, WB; IDLE->READ on instr_valid&&instr_ready, READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-018: instr_ready = 1 only in IDLE; instr_valid in other states is ignored and not queued.
REQ-019: On the accept edge, instr and imm are latched.
REQ-020: On the READ->EXEC edge, alu_a<=R[rs1], alu_b<=R[rs2], alu_fs<=op; these hold stable through EXEC and WB.
REQ-021: On the EXEC->WB edge, alu_c and alu_flag are captured into internal result registers.
REQ-022: done=1 throughout WB, 0 otherwise.
REQ-023: On the WB->IDLE edge: ADD/SUB write result to R[rd]; LDI writes latched imm to R[rd]; CMP writes no register.
REQ-024: Flag update on the same edge: ADD/SUB load flags_q[0] and flags_q[2] from the captured flags and hold [3]; CMP loads flags_q[3] and holds [2] and [0]; LDI holds all flag bits; flags_q[1] is always 0.
REQ-025: Timing: accept at edge T, done high between edges T+2 and T+3, register/flag update at T+3, next accept no earlier than edge T+4 (throughput one instruction per 4 cycles).
REQ-026: rd==rs1 or rd==rs2 is legal; operands are the pre-instruction values.
REQ-027: rd_data reflects writes from the cycle after the write edge.

Reset
REQ-028: rst asserted at any time immediately forces state IDLE, R0-R3=0x00, flags_q=4'b0000, alu_a=alu_b=0x00, alu_fs=2'b00, done=0, instr_ready=0 while rst is high, and clears the latched instruction.
REQ-029: Reset mid-instruction aborts it: no register or flag write occurs; after rst deasserts, instr_ready=1 on the first cycle.

Verification
REQ-030: LDI R1,0x80; LDI R2,0x80; ADD R3,R1,R2 -> R3=0x00, flags_q=4'b0101, done pulses once per instruction.
REQ-031: LDI R1,0x05; LDI R2,0x07; SUB R0,R1,R2 -> R0=0xFE, flags_q[0]=1, flags_q[2]=0, flags_q[3] unchanged.
REQ-032: R1=R2=0x3C, CMP R0,R1,R2 -> R0 unchanged, flags_q[3]=1, bits [2] and [0] unchanged; then CMP with R2=0x3D -> flags_q[3]=0.
REQ-033: instr_valid held high for 12 cycles -> exactly 3 accepts at 4-cycle spacing; instr_ready low in READ/EXEC/WB.
REQ-034: Assert rst during EXEC of ADD R3 -> R3 and flags_q remain 0x00/4'b0000, no done pulse, instr_ready=1 in the first cycle after deassert.
REQ-035: ADD R1,R1,R1 with R1=0x41 -> R1=0x82, flags_q[0]=0, flags_q[2]=0.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// ----------------------------------------------------------------------------
// alu_exec_ctrl
//
// Purpose:
//   Four-state execution controller for an external 8-bit ALU. It accepts one
//   instruction at a time, reads two operands from a 4 x 8-bit register file,
//   presents them to the ALU, captures the ALU result and flags, and retires
//   the instruction into the register file and the architectural flag register.
//   Throughput is one instruction every four cycles.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous active-high reset
//   instr_valid  in   instruction offered
//   instr_ready  out  high only in IDLE (and never while rst is high)
//   instr[7:0]   in   [7:6] op (ADD/SUB/CMP/LDI), [5:4] rd, [3:2] rs1, [1:0] rs2
//   imm[7:0]     in   LDI immediate, sampled together with instr
//   alu_a[7:0]   out  registered ALU operand A (R[rs1])
//   alu_b[7:0]   out  registered ALU operand B (R[rs2])
//   alu_fs[1:0]  out  registered ALU function select (the latched op)
//   alu_c[7:0]   in   ALU result
//   alu_flag[3:0]in   ALU flags: [3] equal, [2] zero, [1] unused, [0] carry/borrow
//   flags_q[3:0] out  architectural flag register, same layout, bit 1 always 0
//   done         out  high for the whole writeback cycle
//   rd_sel[1:0]  in   debug read select
//   rd_data[7:0] out  combinational read of R[rd_sel]
// ----------------------------------------------------------------------------
module alu_exec_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    input  logic [7:0] imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_fs,
    input  logic [7:0] alu_c,
    input  logic [3:0] alu_flag,
    output logic [3:0] flags_q,
    output logic       done,
    input  logic [1:0] rd_sel,
    output logic [7:0] rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10,
        OP_LDI = 2'b11
    } op_t;

    state_t     state_q;
    logic [7:0] instr_q;
    logic [7:0] imm_q;
    logic [7:0] res_q;      // captured ALU result
    logic       eq_q;       // captured compare-equal flag
    logic       zero_q;     // captured zero flag
    logic       carry_q;    // captured carry/borrow flag
    logic [7:0] alu_a_q;
    logic [7:0] alu_b_q;
    logic [1:0] alu_fs_q;
    logic       done_q;
    logic [7:0] regs_q [4];

    // Writeback decisions for the latched instruction.
    logic       wr_en_d;
    logic [7:0] wr_data_d;
    logic [3:0] flags_d;

    op_t        op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;

    // ALU flag bit 1 carries no meaning for this controller.
    logic unused_alu_flag1;
    assign unused_alu_flag1 = alu_flag[1];

    assign op  = op_t'(instr_q[7:6]);
    assign rd  = instr_q[5:4];
    assign rs1 = instr_q[3:2];
    assign rs2 = instr_q[1:0];

    // Ready is a pure decode of IDLE so it rises in the very first cycle after
    // reset is released, and is forced low while reset is held.
    assign instr_ready = (state_q == S_IDLE) && !rst;

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_fs  = alu_fs_q;
    assign done    = done_q;
    assign rd_data = regs_q[rd_sel];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_data_d = res_q;
        flags_d   = flags_q;
        case (op)
            OP_ADD, OP_SUB: begin
                wr_en_d    = 1'b1;
                flags_d[2] = zero_q;
                flags_d[0] = carry_q;
            end
            OP_CMP: begin
                flags_d[3] = eq_q;
            end
            OP_LDI: begin
                wr_en_d   = 1'b1;
                wr_data_d = imm_q;
            end
            default: ;
        endcase
        flags_d[1] = 1'b0;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples values from before the edge (operands read in
    // READ are the pre-instruction register values even when rd == rs1/rs2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            instr_q  <= 8'h00;
            imm_q    <= 8'h00;
            res_q    <= 8'h00;
            eq_q     <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_fs_q <= 2'b00;
            done_q   <= 1'b0;
            flags_q  <= 4'b0000;
            // NOTE: the register file is architecturally defined to read 0x00
            // after reset, so this small array is reset like ordinary flops
            // rather than being left as uninitialised storage.
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        imm_q   <= imm;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    alu_a_q  <= regs_q[rs1];
                    alu_b_q  <= regs_q[rs2];
                    alu_fs_q <= instr_q[7:6];
                    state_q  <= S_EXEC;
                end
                S_EXEC: begin
                    res_q   <= alu_c;
                    eq_q    <= alu_flag[3];
                    zero_q  <= alu_flag[2];
                    carry_q <= alu_flag[0];
                    done_q  <= 1'b1;
                    state_q <= S_WB;
                end
                S_WB: begin
                    if (wr_en_d) begin
                        regs_q[rd] <= wr_data_d;
                    end
                    flags_q <= flags_d;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
